// File: rtl/inj_sched_pkg.sv
// Shared types and helpers for the injection scheduler.
// The state encoding, default flit width and node-index width helper live here.
package inj_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int FLIT_W_DEF = 20;

  // Width of a node index; a single node still needs one bit.
  function automatic int node_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inj_skid_fifo.sv
// Two-entry skid FIFO between the dataout buffers and the injection port.
// The head entry is always presented on dout. Push and pop may happen in the
// same cycle. A push into a full FIFO with no pop is dropped.
module inj_skid_fifo
  import inj_sched_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] din,
  input  logic              pop,
  output logic [FLIT_W-1:0] dout,
  output logic [1:0]        count
);

  logic [FLIT_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop_ok, push_ok;

  // Next-state for the two slots and the occupancy.
  always_comb begin
    pop_ok  = pop && (cnt_q != 2'd0);
    push_ok = push && ((cnt_q != 2'd2) || pop_ok);
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = din;
        else               tail_d = din;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout  = head_q;
  assign count = cnt_q;

endmodule

// File: rtl/inj_sched.sv
// Injection scheduler: walks the selected dataout buffers in ascending node
// order, enables one at a time and merges their flits into one valid/ready
// stream through a 2-entry skid FIFO.
// Optional feature macro: INJ_SCHED_WDOG_EN (abandons a silent buffer after
// WDOG_CYCLES enabled-but-idle cycles and flags proto_err).
module inj_sched
  import inj_sched_pkg::*;
#(
  parameter int NUM_NODES     = 16,
  parameter int FLIT_W        = FLIT_W_DEF,
  parameter int WORDS_PER_BUF = 30,
  parameter int GAP_CYCLES    = 2,
  parameter int WDOG_CYCLES   = 64,
  localparam int NW           = node_idx_w(NUM_NODES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_NODES-1:0]        node_mask,
  output logic [NUM_NODES-1:0]        buf_en,
  input  logic [NUM_NODES-1:0]        buf_valid,
  input  logic [NUM_NODES*FLIT_W-1:0] buf_data,
  output logic [FLIT_W-1:0]           flit_out,
  output logic                        flit_valid,
  input  logic                        flit_ready,
  output logic [NW-1:0]               cur_node,
  output logic                        busy,
  output logic                        done,
  output logic                        proto_err
);

  localparam int RW = $clog2(WORDS_PER_BUF + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t                 state_q, state_d;
  logic [NUM_NODES-1:0]   mask_q, mask_d, sel_mask;
  logic [NW-1:0]          cur_q, cur_d, first_idx, next_idx;
  logic [RW-1:0]          rx_q, rx_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   err_q, err_d;
  logic                   first_found, next_found;
  logic                   sel_v, stray, en_raw, node_end, go_next, start_acc;
  logic                   fifo_push, pop, overflow, wdog_trip;
  logic [1:0]             fifo_cnt;

`ifdef INJ_SCHED_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_q, wdog_d;
`else
  // WDOG_CYCLES has no function without the watchdog.
  logic wdog_cfg_unused;
  assign wdog_cfg_unused = (WDOG_CYCLES > 0);
`endif

  // Lowest set bit of the incoming mask, and next set bit of the latched mask above cur.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_NODES - 1; i >= 0; i--) begin
      if (node_mask[i]) begin
        first_found = 1'b1;
        first_idx   = NW'(i);
      end
      if (mask_q[i] && (i > int'(cur_q))) begin
        next_found = 1'b1;
        next_idx   = NW'(i);
      end
    end
  end

  // FSM next-state, buffer enable, FIFO push and error detection.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cur_d     = cur_q;
    rx_d      = rx_q;
    gap_d     = gap_q;
    err_d     = err_q;
    buf_en    = '0;
    fifo_push = 1'b0;
    done      = 1'b0;
    node_end  = 1'b0;
    go_next   = 1'b0;
    start_acc = 1'b0;
    wdog_trip = 1'b0;
`ifdef INJ_SCHED_WDOG_EN
    wdog_d    = wdog_q;
`endif
    sel_mask         = '0;
    sel_mask[cur_q]  = 1'b1;
    sel_v            = buf_valid[cur_q];
    pop              = flit_valid && flit_ready;
    // Enable only if the word arriving next cycle is guaranteed a FIFO slot.
    en_raw           = (int'(fifo_cnt) + int'(sel_v) - int'(pop)) <= 1;
    stray            = (state_q == STREAM) ? |(buf_valid & ~sel_mask) : |buf_valid;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          mask_d    = node_mask;
          rx_d      = '0;
          gap_d     = '0;
`ifdef INJ_SCHED_WDOG_EN
          wdog_d    = '0;
`endif
          cur_d     = first_found ? first_idx : '0;
          state_d   = first_found ? STREAM : FINISH;
        end
      end
      STREAM: begin
        fifo_push = sel_v;
        if (sel_v) begin
          rx_d = rx_q + RW'(1);
          if (rx_q == RW'(WORDS_PER_BUF - 1)) node_end = 1'b1;
        end
`ifdef INJ_SCHED_WDOG_EN
        if (wdog_q == WW'(WDOG_CYCLES)) begin
          wdog_trip = 1'b1;
          node_end  = 1'b1;
        end else if (sel_v) begin
          wdog_d = '0;
        end else if (en_raw) begin
          wdog_d = wdog_q + WW'(1);
        end
`endif
        buf_en = (en_raw && !node_end) ? sel_mask : '0;
        if (node_end) begin
          rx_d = '0;
`ifdef INJ_SCHED_WDOG_EN
          wdog_d = '0;
`endif
          if (GAP_CYCLES > 0) begin
            gap_d   = '0;
            state_d = GAP;
          end else begin
            go_next = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) go_next = 1'b1;
        else                              gap_d   = gap_q + GW'(1);
      end
      FINISH: begin
        if (fifo_cnt == 2'd0) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_next) begin
      if (next_found) begin
        cur_d   = next_idx;
        state_d = STREAM;
      end else begin
        state_d = FINISH;
      end
    end

    overflow = fifo_push && (fifo_cnt == 2'd2) && !pop;
    if (start_acc) err_d = 1'b0;
    if (stray || overflow || wdog_trip) err_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cur_q   <= '0;
      rx_q    <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      rx_q    <= rx_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

`ifdef INJ_SCHED_WDOG_EN
  // Watchdog counter of enabled cycles without a word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wdog_q <= '0;
    else      wdog_q <= wdog_d;
  end
`endif

  inj_skid_fifo #(.FLIT_W(FLIT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (buf_data[cur_q*FLIT_W +: FLIT_W]),
    .pop   (pop),
    .dout  (flit_out),
    .count (fifo_cnt)
  );

  assign flit_valid = (fifo_cnt != 2'd0);
  assign cur_node   = cur_q;
  assign busy       = (state_q != IDLE);
  assign proto_err  = err_q;

endmodule

// File: tb/tb_inj_sched.sv
// Testbench for inj_sched: behavioural ROM-streamer models per node, a
// flit-list reference built from the node mask, and per-scenario checks.
module tb_inj_sched;
  localparam int N    = 16;
  localparam int FW   = 20;
  localparam int WPB  = 30;
  localparam int GAPC = 2;
  localparam int WDOG = 64;
  localparam int CW   = $clog2(N);

  logic            clk = 1'b0, rst = 1'b1, start = 1'b0, flit_ready = 1'b0;
  logic [N-1:0]    node_mask = '0, buf_en, buf_valid;
  logic [N*FW-1:0] buf_data;
  logic [FW-1:0]   flit_out;
  logic            flit_valid, busy, done, proto_err;
  logic [CW-1:0]   cur_node;

  int errors = 0, checks = 0;

  int           baddr [N];
  logic [N-1:0] bv, inj = '0;
  logic [FW-1:0] bd [N];
  logic         brst = 1'b1;

  logic [FW-1:0] rxq[$];
  int nodeq[$];
  int done_cnt, onehot_bad, first_en_c, first_pop_c, last_pop_c, en0_cnt, timeout, maxcnt;

  always #5 clk = ~clk;

  inj_sched #(.NUM_NODES(N), .FLIT_W(FW), .WORDS_PER_BUF(WPB), .GAP_CYCLES(GAPC),
              .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .start(start), .node_mask(node_mask), .buf_en(buf_en),
    .buf_valid(buf_valid), .buf_data(buf_data), .flit_out(flit_out),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .cur_node(cur_node),
    .busy(busy), .done(done), .proto_err(proto_err));

  function automatic logic [FW-1:0] word(input int n, input int a);
    logic [7:0] nb, ab;
    nb = 8'(n);
    ab = 8'(255 - a);
    return {nb, 4'h0, ab};
  endfunction

  // ROM streamer: one word per enabled cycle, 1-cycle latency, stops after WPB words.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (brst) begin
        baddr[i] <= 0; bv[i] <= 1'b0; bd[i] <= '0;
      end else if (buf_en[i] && baddr[i] < WPB) begin
        bv[i] <= 1'b1; bd[i] <= word(i, baddr[i]); baddr[i] <= baddr[i] + 1;
      end else begin
        bv[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    buf_data  = '0;
    buf_valid = bv | inj;
    for (int i = 0; i < N; i++) buf_data[i*FW +: FW] = inj[i] ? 20'hEEEEE : bd[i];
  end

  // Expected stream: nodes ascending, each node's words in address order.
  function automatic int diff_count(input logic [N-1:0] mask);
    logic [FW-1:0] expq[$];
    int bad = 0;
    for (int n = 0; n < N; n++)
      if (mask[n]) for (int a = 0; a < WPB; a++) expq.push_back(word(n, a));
    if (expq.size() != rxq.size()) bad++;
    for (int i = 0; i < expq.size() && i < rxq.size(); i++)
      if (rxq[i] !== expq[i]) bad++;
    return bad;
  endfunction

  function automatic int node_seq_bad(input logic [N-1:0] mask);
    int expn[$];
    int bad = 0;
    for (int n = 0; n < N; n++) if (mask[n]) expn.push_back(n);
    if (expn.size() != nodeq.size()) bad++;
    for (int i = 0; i < expn.size() && i < nodeq.size(); i++)
      if (expn[i] != nodeq[i]) bad++;
    return bad;
  endfunction

  task automatic fresh_bufs();
    brst = 1'b1;
    @(negedge clk);
    brst = 1'b0;
  endtask

  task automatic run_pass(input logic [N-1:0] mask, input int rmode, input bit do_inj,
                          input bit do_restart, input int maxc);
    int tail;
    bit injd;
    logic [N-1:0] one;
    rxq.delete(); nodeq.delete();
    done_cnt = 0; onehot_bad = 0; first_en_c = -1; first_pop_c = -1; last_pop_c = -1;
    en0_cnt = 0; timeout = 1; maxcnt = 0; tail = -1; injd = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      start     = (c == 0) || (do_restart && c == 40);
      node_mask = (c == 0) ? mask : ~mask;
      inj       = '0;
      case (rmode)
        0:       flit_ready = 1'b1;
        1:       flit_ready = ((c % 3) == 0);
        2:       flit_ready = 1'($urandom_range(0, 1));
        default: flit_ready = 1'b0;
      endcase
      if (do_inj && !injd && buf_en[3] && rxq.size() > 5) begin
        inj[5] = 1'b1;
        injd   = 1'b1;
      end
      if (int'(dut.fifo_cnt) > maxcnt) maxcnt = int'(dut.fifo_cnt);
      if (buf_en != '0) begin
        one = '0; one[cur_node] = 1'b1;
        if (buf_en !== one) onehot_bad++;
        if (nodeq.size() == 0 || nodeq[$] != int'(cur_node)) nodeq.push_back(int'(cur_node));
        if (first_en_c < 0) first_en_c = c;
        if (buf_en[0]) en0_cnt++;
      end
      if (flit_valid && flit_ready) begin
        rxq.push_back(flit_out);
        if (first_pop_c < 0) first_pop_c = c;
        last_pop_c = c;
      end
      if (done) begin
        done_cnt++;
        if (tail < 0) tail = c;
      end
      if (tail >= 0 && c >= tail + 4) begin
        timeout = 0;
        break;
      end
    end
    start = 1'b0;
    inj   = '0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    brst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; brst = 1'b0;
    @(negedge clk);
    checks++; if (buf_en !== '0) begin errors++; $display("FAIL reset_buf_en: got %h want 0", buf_en); end
    checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL reset_flit_valid: got %b want 0", flit_valid); end
    checks++; if (flit_out !== '0) begin errors++; $display("FAIL reset_flit_out: got %h want 0", flit_out); end
    checks++; if (cur_node !== '0) begin errors++; $display("FAIL reset_cur_node: got %0d want 0", cur_node); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
  endtask

  task automatic test_single_node();
    int nb;
    fresh_bufs();
    run_pass(16'h0800, 0, 1'b0, 1'b0, 400);
    nb = diff_count(16'h0800);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL single_timeout: got %0d want 0", timeout); end
    checks++; if (node_seq_bad(16'h0800) !== 0) begin errors++; $display("FAIL single_nodes: got %0d entries want 1 (node 11)", nodeq.size()); end
    checks++; if (first_pop_c - first_en_c !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", first_pop_c - first_en_c); end
    checks++; if (rxq.size() !== 30) begin errors++; $display("FAIL single_count: got %0d want 30", rxq.size()); end
    checks++; if (rxq.size() == 0 || rxq[0] !== 20'h0B0FF) begin errors++; $display("FAIL single_first_flit: got %h want 0b0ff", (rxq.size() > 0) ? rxq[0] : 20'h0); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL single_data: got %0d bad want 0", nb); end
    checks++; if (last_pop_c - first_pop_c !== 29) begin errors++; $display("FAIL single_bubbles: got span %0d want 29", last_pop_c - first_pop_c); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done: got %0d want 1", done_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL single_proto_err: got %b want 0", proto_err); end
    checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL single_onehot: got %0d want 0", onehot_bad); end
  endtask

  task automatic test_gap_two_nodes();
    fresh_bufs();
    run_pass(16'h0003, 0, 1'b0, 1'b0, 400);
    checks++; if (node_seq_bad(16'h0003) !== 0) begin errors++; $display("FAIL gap_nodes: got %0d entries want 0,1", nodeq.size()); end
    checks++; if (rxq.size() !== 60) begin errors++; $display("FAIL gap_count: got %0d want 60", rxq.size()); end
    checks++; if (diff_count(16'h0003) !== 0) begin errors++; $display("FAIL gap_data: got %0d bad want 0", diff_count(16'h0003)); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL gap_done: got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_ready_toggle();
    logic [N-1:0] m;
    fresh_bufs();
    m = 16'h0240;
    run_pass(m, 1, 1'b0, 1'b0, 1000);
    checks++; if (rxq.size() !== 60) begin errors++; $display("FAIL toggle_count: got %0d want 60", rxq.size()); end
    checks++; if (diff_count(m) !== 0) begin errors++; $display("FAIL toggle_data: got %0d bad want 0", diff_count(m)); end
    checks++; if (maxcnt > 2) begin errors++; $display("FAIL toggle_fifo_occ: got %0d want <=2", maxcnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL toggle_done: got %0d want 1", done_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL toggle_proto_err: got %b want 0", proto_err); end
  endtask

  task automatic test_random_passes();
    logic [N-1:0] m;
    for (int it = 0; it < 4; it++) begin
      m = 16'($urandom) & 16'($urandom);
      if (m == '0) m[it] = 1'b1;
      fresh_bufs();
      run_pass(m, 2, 1'b0, 1'b0, 4000);
      checks++; if (diff_count(m) !== 0) begin errors++; $display("FAIL rand_data[%0d]: mask %h got %0d bad want 0", it, m, diff_count(m)); end
      checks++; if (node_seq_bad(m) !== 0) begin errors++; $display("FAIL rand_nodes[%0d]: mask %h got %0d entries", it, m, nodeq.size()); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rand_done[%0d]: got %0d want 1", it, done_cnt); end
      checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL rand_onehot[%0d]: got %0d want 0", it, onehot_bad); end
    end
  endtask

  task automatic test_mask_zero();
    run_pass('0, 0, 1'b0, 1'b0, 50);
    checks++; if (rxq.size() !== 0) begin errors++; $display("FAIL zero_count: got %0d want 0", rxq.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done: got %0d want 1", done_cnt); end
    checks++; if (nodeq.size() !== 0) begin errors++; $display("FAIL zero_enables: got %0d want 0", nodeq.size()); end
  endtask

  task automatic test_stray_and_restart();
    fresh_bufs();
    run_pass(16'h0018, 0, 1'b1, 1'b1, 600);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL stray_proto_err: got %b want 1", proto_err); end
    checks++; if (rxq.size() !== 60) begin errors++; $display("FAIL stray_count: got %0d want 60", rxq.size()); end
    checks++; if (diff_count(16'h0018) !== 0) begin errors++; $display("FAIL stray_data: got %0d bad want 0", diff_count(16'h0018)); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stray_done: got %0d want 1", done_cnt); end
  endtask

`ifdef INJ_SCHED_WDOG_EN
  task automatic test_wdog();
    fresh_bufs();
    run_pass(16'h0003, 0, 1'b0, 1'b0, 400);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL wdog_first_pass_err: got %b want 0", proto_err); end
    run_pass(16'h0003, 0, 1'b0, 1'b0, 600);
    checks++; if (rxq.size() !== 0) begin errors++; $display("FAIL wdog_count: got %0d want 0", rxq.size()); end
    checks++; if (en0_cnt !== WDOG) begin errors++; $display("FAIL wdog_en_cycles: got %0d want %0d", en0_cnt, WDOG); end
    checks++; if (node_seq_bad(16'h0003) !== 0) begin errors++; $display("FAIL wdog_nodes: got %0d entries want 0,1", nodeq.size()); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL wdog_proto_err: got %b want 1", proto_err); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wdog_done: got %0d want 1", done_cnt); end
  endtask
`endif

  task automatic test_reset_mid_stream();
    fresh_bufs();
    run_pass(16'h0001, 3, 1'b0, 1'b0, 12);
    checks++; if (dut.fifo_cnt !== 2'd2) begin errors++; $display("FAIL rstmid_fifo_full: got %0d want 2", dut.fifo_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    checks++; if (buf_en !== '0) begin errors++; $display("FAIL rstmid_buf_en: got %h want 0", buf_en); end
    checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flit_valid: got %b want 0", flit_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fresh_bufs();
    run_pass(16'h0001, 0, 1'b0, 1'b0, 400);
    checks++; if (diff_count(16'h0001) !== 0) begin errors++; $display("FAIL rstmid_rerun_data: got %0d bad want 0", diff_count(16'h0001)); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rstmid_rerun_done: got %0d want 1", done_cnt); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rstmid_rerun_err: got %b want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_single_node();
    test_gap_two_nodes();
    test_ready_toggle();
    test_random_passes();
    test_mask_zero();
    test_stray_and_restart();
`ifdef INJ_SCHED_WDOG_EN
    test_wdog();
`endif
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
